// File: rtl/control_fsm_pkg.sv
// Shared types and constants for the instruction-sequencing controller:
// state encoding, ALU operation codes, data-processing opcodes and condition codes.
package cpu_pkg;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC   = 4'd3,
        S_ALUWB  = 4'd4,
        S_MEMADR = 4'd5,
        S_MEMRD  = 4'd6,
        S_MEMWB  = 4'd7,
        S_MEMWR  = 4'd8,
        S_BRANCH = 4'd9
    } state_e;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;

    localparam logic [3:0] OPC_ADD = 4'b0100;
    localparam logic [3:0] OPC_SUB = 4'b0010;
    localparam logic [3:0] OPC_AND = 4'b0000;
    localparam logic [3:0] OPC_ORR = 4'b1100;
    localparam logic [3:0] OPC_CMP = 4'b1010;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    typedef struct packed {
        logic [1:0] alu_op;
        logic       wb;
        logic       is_cmp;
    } dp_dec_t;

    // Unknown opcodes run as ADD but never write back.
    function automatic dp_dec_t dp_decode(input logic [3:0] opcode);
        dp_dec_t d;
        d = '{alu_op: ALU_ADD, wb: 1'b0, is_cmp: 1'b0};
        case (opcode)
            OPC_ADD: d.wb = 1'b1;
            OPC_SUB: begin d.alu_op = ALU_SUB; d.wb = 1'b1; end
            OPC_AND: begin d.alu_op = ALU_AND; d.wb = 1'b1; end
            OPC_ORR: begin d.alu_op = ALU_ORR; d.wb = 1'b1; end
            OPC_CMP: begin d.alu_op = ALU_SUB; d.is_cmp = 1'b1; end
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/control_fsm_if.sv
// Instruction-field inputs and datapath-control outputs of the controller,
// bundled so the decoder side (master) and controller side (slave) share one port.
interface control_fsm_if;
    logic       start;
    logic [3:0] cond;
    logic [1:0] op;
    logic       funct_i;
    logic [3:0] opcode;
    logic       s_bit;
    logic       l_bit;
    logic [3:0] alu_flags;
    logic       pc_we;
    logic       ir_we;
    logic       branch;
    logic       we_RF;
    logic       we_RAM;
    logic       ena_mux1;
    logic       ena_mux2;
    logic [1:0] alu_opCode;
    logic       busy;

    modport master (
        output start, cond, op, funct_i, opcode, s_bit, l_bit, alu_flags,
        input  pc_we, ir_we, branch, we_RF, we_RAM, ena_mux1, ena_mux2, alu_opCode, busy
    );

    modport slave (
        input  start, cond, op, funct_i, opcode, s_bit, l_bit, alu_flags,
        output pc_we, ir_we, branch, we_RF, we_RAM, ena_mux1, ena_mux2, alu_opCode, busy
    );
endinterface

// File: rtl/control_fsm_cond_check.sv
// Combinational condition-code evaluator: maps a 4-bit cond field and NZCV to pass/fail.
module cond_check
    import cpu_pkg::*;
(
    input  logic [3:0] cond_i,
    input  logic [3:0] nzcv_i,
    output logic       pass_o
);
    logic n, z, c, v;
    assign {n, z, c, v} = nzcv_i;

    always_comb begin
        pass_o = 1'b0;
        case (cond_i)
            COND_EQ: pass_o = z;
            COND_NE: pass_o = ~z;
            COND_CS: pass_o = c;
            COND_CC: pass_o = ~c;
            COND_MI: pass_o = n;
            COND_PL: pass_o = ~n;
            COND_VS: pass_o = v;
            COND_VC: pass_o = ~v;
            COND_HI: pass_o = c & ~z;
            COND_LS: pass_o = ~c | z;
            COND_GE: pass_o = (n == v);
            COND_LT: pass_o = (n != v);
            COND_GT: pass_o = ~z & (n == v);
            COND_LE: pass_o = z | (n != v);
            COND_AL: pass_o = 1'b1;
            default: pass_o = 1'b0;
        endcase
    end
endmodule

// File: rtl/control_fsm.sv
// Multi-cycle instruction sequencer with Moore-decoded datapath strobes.
// Define COND_EXEC_EN to enable conditional execution via an internal NZCV register.
//
// state   | meaning
// IDLE    | waiting for start
// FETCH   | instruction fetch, 1+FETCH_WAIT cycles, strobes on last cycle
// DECODE  | condition check and instruction-class dispatch
// EXEC    | data-processing ALU operation
// ALUWB   | ALU result written to register file
// MEMADR  | address computation (base + immediate)
// MEMRD   | data-memory read
// MEMWB   | loaded data written to register file
// MEMWR   | data-memory write
// BRANCH  | PC loaded from branch target
module control_fsm
    import cpu_pkg::*;
#(
    parameter int FETCH_WAIT = 1
) (
    input logic          clk,
    input logic          rst,
    control_fsm_if.slave bus
);
    localparam logic [1:0] WAIT_LOAD = 2'(FETCH_WAIT);

    state_e     state_q, state_d;
    logic [1:0] wait_q, wait_d;
    logic [1:0] alu_op_q, alu_op_d;
    logic       wb_q, wb_d;
    logic       funct_q, funct_d;
    logic       setf_q, setf_d;
    logic       lbit_q, lbit_d;
    logic       cond_pass;
    dp_dec_t    dp_dec;

    assign dp_dec = dp_decode(bus.opcode);

`ifdef COND_EXEC_EN
    logic [3:0] nzcv_q, nzcv_d;

    cond_check u_cond_check (
        .cond_i (bus.cond),
        .nzcv_i (nzcv_q),
        .pass_o (cond_pass)
    );

    always_ff @(posedge clk) begin
        if (!rst) nzcv_q <= '0;
        else      nzcv_q <= nzcv_d;
    end

    always_comb begin
        nzcv_d = nzcv_q;
        if (state_q == S_EXEC && setf_q) nzcv_d = bus.alu_flags;
    end
`else
    logic unused_cond;
    assign cond_pass   = 1'b1;
    assign unused_cond = ^{bus.cond, bus.alu_flags, setf_q};
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            wait_q   <= '0;
            alu_op_q <= ALU_ADD;
            wb_q     <= 1'b0;
            funct_q  <= 1'b0;
            setf_q   <= 1'b0;
            lbit_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            alu_op_q <= alu_op_d;
            wb_q     <= wb_d;
            funct_q  <= funct_d;
            setf_q   <= setf_d;
            lbit_q   <= lbit_d;
        end
    end

    // Instruction fields are captured in DECODE so later states decode only registers.
    always_comb begin
        state_d  = state_q;
        wait_d   = WAIT_LOAD;
        alu_op_d = alu_op_q;
        wb_d     = wb_q;
        funct_d  = funct_q;
        setf_d   = setf_q;
        lbit_d   = lbit_q;
        case (state_q)
            S_IDLE:   if (bus.start) state_d = S_FETCH;
            S_FETCH: begin
                if (wait_q == WAIT_LOAD && !bus.start) state_d = S_IDLE;
                else if (wait_q == 2'd0)               state_d = S_DECODE;
                else                                   wait_d  = wait_q - 2'd1;
            end
            S_DECODE: begin
                alu_op_d = dp_dec.alu_op;
                wb_d     = dp_dec.wb;
                funct_d  = bus.funct_i;
                setf_d   = bus.s_bit | dp_dec.is_cmp;
                lbit_d   = bus.l_bit;
                if (!cond_pass || bus.op == OP_ILL) state_d = S_FETCH;
                else if (bus.op == OP_DP)           state_d = S_EXEC;
                else if (bus.op == OP_MEM)          state_d = S_MEMADR;
                else                                state_d = S_BRANCH;
            end
            S_EXEC:   state_d = wb_q ? S_ALUWB : S_FETCH;
            S_MEMADR: state_d = lbit_q ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = S_MEMWB;
            S_ALUWB, S_MEMWB, S_MEMWR, S_BRANCH: state_d = S_FETCH;
            default:  state_d = S_IDLE;
        endcase
    end

    logic fetch_last;
    assign fetch_last = (state_q == S_FETCH) && (wait_q == 2'd0);

    assign bus.pc_we      = fetch_last || (state_q == S_BRANCH);
    assign bus.ir_we      = fetch_last;
    assign bus.branch     = (state_q == S_BRANCH);
    assign bus.we_RF      = (state_q == S_ALUWB) || (state_q == S_MEMWB);
    assign bus.we_RAM     = (state_q == S_MEMWR);
    assign bus.ena_mux1   = (state_q == S_EXEC) ? funct_q : (state_q == S_MEMADR);
    assign bus.ena_mux2   = (state_q == S_MEMWB);
    assign bus.alu_opCode = (state_q == S_EXEC) ? alu_op_q : ALU_ADD;
    assign bus.busy       = (state_q != S_IDLE);
endmodule
